// File: rtl/fifo_param_if.sv
// Producer/consumer bus of the parametrised FIFO.
// The master side drives requests and write data.
// The slave side (the FIFO) returns read data, status and error flags.
interface fifo_param_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 3
);

  logic              en;
  logic              wr;
  logic [DWIDTH-1:0] dataIn;
  logic              rd;
  logic [DWIDTH-1:0] dataOut;
  logic              clr_err;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AWIDTH:0]   level;
  logic              overflow;
  logic              underflow;

  modport master (
    output en,
    output wr,
    output dataIn,
    output rd,
    output clr_err,
    input  dataOut,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  level,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  en,
    input  wr,
    input  dataIn,
    input  rd,
    input  clr_err,
    output dataOut,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output level,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO.
// Supports simultaneous read/write and standard or first-word-fall-through output.
// Provides programmable almost-full/almost-empty thresholds, an occupancy count,
// and sticky overflow/underflow flags.
module fifo_param #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned AWIDTH   = 3,
  parameter bit          FWFT     = 1'b0,
  parameter int unsigned AF_LEVEL = (1 << AWIDTH) - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic       clk,
  input logic       rst_n,
  fifo_param_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  // Threshold constants sized to the occupancy counter.
  localparam logic [AWIDTH:0] LvlDepth = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0] LvlAf    = AF_LEVEL[AWIDTH:0];
  localparam logic [AWIDTH:0] LvlAe    = AE_LEVEL[AWIDTH:0];

  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_level;
  logic              r_overflow;
  logic              r_underflow;

  logic [AWIDTH-1:0] w_wr_ptr_d;
  logic [AWIDTH-1:0] w_rd_ptr_d;
  logic [AWIDTH:0]   w_level_d;
  logic              w_overflow_d;
  logic              w_underflow_d;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_evt;
  logic w_unf_evt;
  logic w_clr;

  // Status decode from the registered level and request acceptance.
  always_comb begin
    w_full    = (r_level == LvlDepth);
    w_empty   = (r_level == '0);
    w_rd_acc  = bus.en & bus.rd & ~w_empty;
    // A full FIFO still takes a write when a pop frees a slot in the same cycle.
    w_wr_acc  = bus.en & bus.wr & (~w_full | w_rd_acc);
    w_ovf_evt = bus.en & bus.wr & ~w_wr_acc;
    w_unf_evt = bus.en & bus.rd & w_empty;
    w_clr     = bus.en & bus.clr_err;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    w_wr_ptr_d    = r_wr_ptr;
    w_rd_ptr_d    = r_rd_ptr;
    w_level_d     = r_level;
    w_overflow_d  = r_overflow;
    w_underflow_d = r_underflow;

    if (w_wr_acc) begin
      w_wr_ptr_d = r_wr_ptr + 1'b1;
    end
    if (w_rd_acc) begin
      w_rd_ptr_d = r_rd_ptr + 1'b1;
    end

    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_d = r_level + 1'b1;
      2'b01:   w_level_d = r_level - 1'b1;
      default: w_level_d = r_level;
    endcase

    // A new error in the same cycle as a clear leaves the flag set.
    if (w_clr) begin
      w_overflow_d  = 1'b0;
      w_underflow_d = 1'b0;
    end
    if (w_ovf_evt) begin
      w_overflow_d = 1'b1;
    end
    if (w_unf_evt) begin
      w_underflow_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_level     <= w_level_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.dataIn;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented directly; the value while empty carries no meaning.
    assign bus.dataOut = w_empty ? '0 : r_mem[r_rd_ptr];
  end else begin : g_std
    logic [DWIDTH-1:0] r_dout;

    // Registered read port: loads the head word on each accepted pop, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dout <= '0;
      end else if (w_rd_acc) begin
        r_dout <= r_mem[r_rd_ptr];
      end
    end

    assign bus.dataOut = r_dout;
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_level >= LvlAf);
  assign bus.almost_empty = (r_level <= LvlAe);
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the team's 8x8 FIFO. It adds simultaneous read/write, selectable standard or first-word-fall-through (FWFT) output, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It sits between producer and consumer blocks in a single clock domain.

## Interface
- DWIDTH, 8: data word width in bits.
- AWIDTH, 3: address width; DEPTH = 2**AWIDTH entries.
- FWFT, 0: 0 = standard read (data one cycle after rd); 1 = head word presented on dataOut while not empty.
- AF_LEVEL, DEPTH-1: almost_full asserts when level >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when level <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when 0, no accept, no error capture, all state held.
- wr  in  1  write request.
- dataIn  in  DWIDTH  write data.
- rd  in  1  read request (pop).
- dataOut  out  DWIDTH  read data.
- clr_err  in  1  synchronous clear of overflow/underflow.
- full, empty, almost_full, almost_empty  out  1  status flags.
- level  out  AWIDTH+1  current occupancy, 0..DEPTH.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Reset (rst_n low, asynchronous): rd/wr pointers = 0, level = 0, dataOut = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0 (unless AF_LEVEL = 0, which is illegal), overflow = 0, underflow = 0. Array contents are not reset.
- rd_acc = en & rd & !empty.
- wr_acc = en & wr & (!full | rd_acc). A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- Read and write in the same cycle are both performed; level is unchanged.
- Pointers are AWIDTH bits and wrap naturally from DEPTH-1 to 0.
- level update: +1 on wr_acc only, -1 on rd_acc only, otherwise unchanged.
- Flags decode from the registered level: full = (level == DEPTH), empty = (level == 0), almost_full = (level >= AF_LEVEL), almost_empty = (level <= AE_LEVEL).
- Standard mode (FWFT=0): on rd_acc, dataOut <= mem[rd_ptr]. Otherwise dataOut holds its last value.
- FWFT mode (FWFT=1):
  - dataOut = mem[rd_ptr] whenever !empty; rd_acc advances to the next word.
  - dataOut while empty is don't-care; the bench must not check it.
- overflow sets on en & wr & !wr_acc. underflow sets on en & rd & empty.
- Both error flags stay set until clr_err or reset. If clr_err and a new error occur in the same cycle, set wins.
- Rejected requests do not change pointers, level or data.

## Timing
- Write to flag: level, empty and full update the cycle after the accepting edge.
- Standard mode read latency: 1 cycle from the rd_acc edge to dataOut valid.
- FWFT mode: write into an empty FIFO is visible on dataOut the cycle after the write edge, together with empty falling.
- Full with rd=1 and wr=1: both accepted, level stays DEPTH, full stays 1.
- Empty with rd=1 and wr=1: write accepted, read rejected, underflow sets, level becomes 1.
- Reset asserted mid-operation clears state immediately, independent of clk. Operation resumes on the first clk edge after rst_n deasserts.

## Test plan
- Reset, then fill: 8 writes of 0x10..0x17 (DWIDTH=8, AWIDTH=3) -> level steps 1..8; almost_full at level 7; full at 8. A 9th write sets overflow, level stays 8.
- Drain, standard mode: 8 reads -> dataOut 0x10..0x17, each one cycle after its read; empty after the 8th. A 9th read sets underflow and dataOut holds 0x17.
- Simultaneous rd+wr at level 4 for 20 cycles, wrapping the pointers -> level stays 4 and output order matches input order.
- Full plus simultaneous rd/wr -> both accepted, no overflow. Empty plus simultaneous rd/wr -> underflow = 1, level = 1.
- FWFT=1: write 0xA5 into an empty FIFO -> dataOut = 0xA5 and empty = 0 the next cycle. rd -> empty = 1 the next cycle.
- en=0 with rd/wr toggling -> no state change and no error flags. rst_n pulsed low mid-burst -> all outputs at reset values asynchronously. clr_err plus a new overflow in the same cycle -> overflow stays 1.
